// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: prepends preamble/SFD, zero-pads short payloads, appends the
// IEEE 802.3 CRC-32 FCS and holds the line idle for the inter-frame gap.
module gmii_tx_framer #(
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned IFG_LEN = 12
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    StIdle, StPreamble, StSfd, StData, StPad, StFcs, StIfg
  } state_e;

  localparam logic [11:0] MinLen  = 12'(MIN_LEN);
  localparam logic [7:0]  IfgLast = 8'(IFG_LEN - 1);

  state_e      state_q;
  logic [10:0] byte_cnt_q, byte_cnt_inc;
  logic [7:0]  phase_q, fcs_byte, crc_din;
  logic [31:0] crc_q, crc_next;
  logic        min_reached;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] din);
    logic [31:0] c;
    c = crc ^ {24'h0, din};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  always_comb begin
    byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
    min_reached  = {1'b0, byte_cnt_inc} >= MinLen;
    crc_din      = (state_q == StData) ? in_data : 8'h00;
    crc_next     = crc32_byte(crc_q, crc_din);
    unique case (phase_q[1:0])
      2'd0:    fcs_byte = ~crc_q[7:0];
      2'd1:    fcs_byte = ~crc_q[15:8];
      2'd2:    fcs_byte = ~crc_q[23:16];
      default: fcs_byte = ~crc_q[31:24];
    endcase
  end

  assign in_ready = (state_q == StData);
  assign busy     = (state_q != StIdle);

  // Outputs are registered one edge ahead of the state that names them, so the
  // first preamble byte leaves on the edge that sees in_valid in IDLE.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      gmii_txd    <= 8'h00;
      gmii_tx_en  <= 1'b0;
      underrun    <= 1'b0;
      frame_count <= 16'h0000;
      crc_q       <= 32'hFFFFFFFF;
      byte_cnt_q  <= 11'd0;
      phase_q     <= 8'd0;
    end else begin
      underrun <= 1'b0;
      case (state_q)
        StIdle: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          crc_q      <= 32'hFFFFFFFF;
          byte_cnt_q <= 11'd0;
          phase_q    <= 8'd0;
          if (in_valid) begin
            state_q    <= StPreamble;
            gmii_tx_en <= 1'b1;
            gmii_txd   <= 8'h55;
          end
        end
        StPreamble: begin
          gmii_txd <= 8'h55;
          phase_q  <= phase_q + 8'd1;
          if (phase_q == 8'd5) begin
            state_q <= StSfd;
            phase_q <= 8'd0;
          end
        end
        StSfd: begin
          gmii_txd <= 8'hD5;
          state_q  <= StData;
        end
        StData: begin
          if (in_valid) begin
            gmii_txd   <= in_data;
            crc_q      <= crc_next;
            byte_cnt_q <= byte_cnt_inc;
            if (in_last) state_q <= min_reached ? StFcs : StPad;
          end else begin
            underrun   <= 1'b1;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= 8'h00;
            state_q    <= StIfg;
          end
        end
        StPad: begin
          gmii_txd   <= 8'h00;
          crc_q      <= crc_next;
          byte_cnt_q <= byte_cnt_inc;
          if (min_reached) state_q <= StFcs;
        end
        StFcs: begin
          gmii_txd <= fcs_byte;
          phase_q  <= phase_q + 8'd1;
          if (phase_q == 8'd3) begin
            state_q     <= StIfg;
            phase_q     <= 8'd0;
            frame_count <= frame_count + 16'd1;
          end
        end
        StIfg: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          phase_q    <= phase_q + 8'd1;
          if (phase_q == IfgLast) begin
            state_q <= StIdle;
            phase_q <= 8'd0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: a per-cycle expected line timeline built from frame-level
// rules, plus literal expectations on lengths, gaps, CRC residue and frame counts.
module tb_gmii_tx_framer;

  localparam int MinLen = 60;
  localparam int IfgLen = 12;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [7:0]  in_data;
  logic        in_valid, in_last;
  logic        in_ready;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en, busy, underrun;
  logic [15:0] frame_count;

  gmii_tx_framer #(.MIN_LEN(MinLen), .IFG_LEN(IfgLen)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .gmii_txd    (gmii_txd),
    .gmii_tx_en  (gmii_tx_en),
    .busy        (busy),
    .underrun    (underrun),
    .frame_count (frame_count)
  );

  always #4 sys_clk = ~sys_clk;

  typedef struct packed {
    logic       en;
    logic [7:0] d;
    logic       und;
    logic       bsy;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic en, input logic [7:0] d, input logic u, input logic b);
    return {en, d, u, b};
  endfunction

  // Bit-serial reflected CRC-32 register (no final inversion).
  function automatic logic [31:0] crc_reg(input logic [7:0] b[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  // Expected line activity for one complete frame, followed by its gap.
  task automatic push_frame(input logic [7:0] p[$], input bit lead);
    logic [7:0]  body[$];
    logic [31:0] fcs;
    body = p;
    while (body.size() < MinLen) body.push_back(8'h00);
    fcs = ~crc_reg(body);
    if (lead) exp_q.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0));
    repeat (7) exp_q.push_back(mk(1'b1, 8'h55, 1'b0, 1'b1));
    exp_q.push_back(mk(1'b1, 8'hD5, 1'b0, 1'b1));
    foreach (body[i]) exp_q.push_back(mk(1'b1, body[i], 1'b0, 1'b1));
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(1'b1, fcs[8*k +: 8], 1'b0, 1'b1));
    for (int k = 0; k < IfgLen; k++) exp_q.push_back(mk(1'b0, 8'h00, 1'b0, k != IfgLen - 1));
  endtask

  // Expected activity when the source stalls after k payload bytes.
  task automatic push_underrun(input logic [7:0] p[$], input int k);
    exp_q.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0));
    repeat (7) exp_q.push_back(mk(1'b1, 8'h55, 1'b0, 1'b1));
    exp_q.push_back(mk(1'b1, 8'hD5, 1'b0, 1'b1));
    for (int i = 0; i < k; i++) exp_q.push_back(mk(1'b1, p[i], 1'b0, 1'b1));
    exp_q.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1));
    for (int i = 0; i < IfgLen; i++) exp_q.push_back(mk(1'b0, 8'h00, 1'b0, i != IfgLen - 1));
  endtask

  // Hands over stop_after bytes of p; called and returns at posedge+1.
  task automatic drive(input logic [7:0] p[$], input int stop_after, input bit keep_valid);
    int i;
    int guard;
    bit hs;
    i = 0;
    guard = 0;
    in_valid = 1'b1;
    in_data  = p[0];
    in_last  = (p.size() == 1);
    while (i < stop_after && guard < 4000) begin
      @(negedge sys_clk);
      hs = in_ready && in_valid;
      @(posedge sys_clk);
      #1;
      guard++;
      if (hs) begin
        i++;
        if (i < p.size()) begin
          in_data = p[i];
          in_last = (i == p.size() - 1);
        end
      end
    end
    check("drive_handshakes", 32'(i), 32'(stop_after));
    if (!keep_valid) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge sys_clk);
    #1;
  endtask

  // Per-cycle compare against the expected timeline; empty timeline means idle line.
  initial forever begin
    @(negedge sys_clk);
    if (chk_en) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : mk(1'b0, 8'h00, 1'b0, 1'b0);
      check("tx_en", 32'(gmii_tx_en), 32'(e.en));
      check("txd", 32'(gmii_txd), 32'(e.d));
      check("underrun", 32'(underrun), 32'(e.und));
      check("busy", 32'(busy), 32'(e.bsy));
    end
  end

  // Frame-level observation: burst length, gap length, bytes after SFD.
  int         run_len = 0, last_run = 0, zero_len = 0, last_gap = 0;
  logic [7:0] cur[$], last_bytes[$];
  logic       prev_en = 1'b0;

  initial forever begin
    @(negedge sys_clk);
    if (gmii_tx_en) begin
      if (!prev_en) begin
        last_gap = zero_len;
        run_len  = 0;
        cur.delete();
      end
      run_len++;
      cur.push_back(gmii_txd);
    end else begin
      if (prev_en) begin
        last_run = run_len;
        last_bytes.delete();
        for (int i = 8; i < cur.size(); i++) last_bytes.push_back(cur[i]);
        zero_len = 0;
      end
      zero_len++;
    end
    prev_en = gmii_tx_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] p64[$], p9[$], pa[$], pb[$], p40[$], pc[$];
  int         zeros;

  initial begin
    for (int i = 0; i < 64; i++) p64.push_back(8'(i * 37 + 5));
    for (int i = 0; i < 9; i++) p9.push_back(8'(8'h31 + i));
    for (int i = 0; i < 60; i++) begin
      pa.push_back(8'(i ^ 8'hA5));
      pb.push_back(8'(255 - i));
      pc.push_back(8'(i * 3));
    end
    for (int i = 0; i < 40; i++) p40.push_back(8'(i + 8'h40));

    check("model_crc_check", ~crc_reg(p9), 32'hCBF43926);

    sys_rst  = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    #1;
    check("rst_tx_en", 32'(gmii_tx_en), 32'd0);
    check("rst_txd", 32'(gmii_txd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    chk_en  = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;

    // 64-byte payload, no padding
    push_frame(p64, 1'b1);
    drive(p64, 64, 1'b0);
    drain();
    check("len64_tx_en_cycles", 32'(last_run), 32'd76);
    check("len64_residue", crc_reg(last_bytes), 32'hDEBB20E3);
    check("len64_frame_count", 32'(frame_count), 32'd1);

    // 9-byte payload padded to 60
    push_frame(p9, 1'b1);
    drive(p9, 9, 1'b0);
    drain();
    zeros = 0;
    for (int i = 9; i < 60 && i < last_bytes.size(); i++) if (last_bytes[i] == 8'h00) zeros++;
    check("pad_tx_en_cycles", 32'(last_run), 32'd72);
    check("pad_zero_bytes", 32'(zeros), 32'd51);
    check("pad_residue", crc_reg(last_bytes), 32'hDEBB20E3);
    check("pad_frame_count", 32'(frame_count), 32'd2);

    // Back-to-back 60-byte frames with in_valid held
    push_frame(pa, 1'b1);
    drive(pa, 60, 1'b1);
    push_frame(pb, 1'b0);
    drive(pb, 60, 1'b0);
    drain();
    check("b2b_gap", 32'(last_gap), 32'd12);
    check("b2b_tx_en_cycles", 32'(last_run), 32'd72);
    check("b2b_frame_count", 32'(frame_count), 32'd4);

    // Underrun after 20 bytes
    push_underrun(p40, 20);
    drive(p40, 20, 1'b0);
    drain();
    check("und_tx_en_cycles", 32'(last_run), 32'd28);
    check("und_frame_count", 32'(frame_count), 32'd4);

    // Reset during payload byte 30
    push_frame(pc, 1'b1);
    drive(pc, 30, 1'b1);
    chk_en = 1'b0;
    exp_q.delete();
    #1;
    sys_rst = 1'b1;
    #1;
    check("midrst_tx_en", 32'(gmii_tx_en), 32'd0);
    check("midrst_txd", 32'(gmii_txd), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_frame_count", 32'(frame_count), 32'd0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    chk_en  = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;
    push_frame(pc, 1'b1);
    drive(pc, 60, 1'b0);
    drain();
    check("postrst_tx_en_cycles", 32'(last_run), 32'd72);
    check("postrst_residue", crc_reg(last_bytes), 32'hDEBB20E3);
    check("postrst_frame_count", 32'(frame_count), 32'd1);

    // Frame counter wrap
    force dut.frame_count = 16'hFFFF;
    @(posedge sys_clk);
    #1;
    release dut.frame_count;
    #1;
    check("wrap_preload", 32'(frame_count), 32'h0000FFFF);
    push_frame(pa, 1'b1);
    drive(pa, 60, 1'b0);
    drain();
    check("wrap_frame_count", 32'(frame_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gmii_tx_framer.md
GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

Interface
REQ-001 SHALL have parameter MIN_LEN, default 60, minimum pre-FCS frame length in bytes (pad target).
REQ-002 SHALL have parameter IFG_LEN, default 12, idle byte-times enforced after each frame.
REQ-003 SHALL have port sys_clk  input  1  single clock for all logic (125 MHz GMII TX domain).
REQ-004 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_data  input  8  payload byte (dst MAC first, no preamble/FCS).
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_last  input  1  in_data is the final payload byte.
REQ-008 SHALL have port in_ready  output  1  framer accepts byte this cycle.
REQ-009 SHALL have port gmii_txd  output  8  GMII transmit data.
REQ-010 SHALL have port gmii_tx_en  output  1  GMII transmit enable.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse when a frame is aborted by in_valid low mid-payload.
REQ-013 SHALL have port frame_count  output  16  completed frames, wraps 0xFFFF->0x0000.

Function
REQ-014 SHALL implement states IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG.
REQ-015 SHALL register gmii_txd and gmii_tx_en; in_ready is combinational, high only in DATA.
REQ-016 IDLE: gmii_tx_en=0, gmii_txd=0x00; in_valid=1 at edge -> PREAMBLE; no byte consumed in IDLE.
REQ-017 PREAMBLE: 7 cycles of txd=0x55, tx_en=1, first one cycle after the IDLE edge that saw in_valid; then SFD: 1 cycle txd=0xD5.
REQ-018 DATA: byte accepted when in_valid&in_ready at an edge; it appears on gmii_txd the following cycle with tx_en=1.
REQ-019 Payload byte counter SHALL be 11 bits, saturating at 2047; no maximum-length truncation.
REQ-020 in_last accepted: if counted bytes < MIN_LEN -> PAD, else -> FCS.
REQ-021 PAD: emit 0x00 until total pre-FCS bytes = MIN_LEN; pad bytes included in CRC.
REQ-022 CRC: IEEE 802.3 CRC-32, reflected poly 0xEDB88320, init 0xFFFFFFFF, over payload+pad; FCS = ~crc, sent LSB byte first, 4 cycles, tx_en=1.
REQ-023 FCS done -> IFG; frame_count increments by 1 on the FCS->IFG transition.
REQ-024 IFG: tx_en=0, txd=0x00, exactly IFG_LEN cycles, in_ready=0, then IDLE; new frame's first preamble byte no sooner than IFG_LEN+1 cycles after last FCS byte.
REQ-025 Underrun: in_valid=0 in DATA -> underrun pulse, tx_en=0 next cycle, no FCS, frame_count unchanged, -> IFG.
REQ-026 in_valid while not in DATA/IDLE SHALL be ignored (held by source, in_ready=0).
REQ-027 in_last with MIN_LEN already reached exactly at that byte -> FCS directly, zero pad bytes.

Reset
REQ-028 sys_rst=1 SHALL asynchronously force: state IDLE, gmii_tx_en=0, gmii_txd=0x00, in_ready=0, busy=0, underrun=0, frame_count=0, CRC=0xFFFFFFFF, byte counter=0.
REQ-029 Reset asserted mid-frame SHALL drop gmii_tx_en immediately; after release, no residual bytes emitted; next frame starts from preamble.

Verification
REQ-030 64-byte payload, in_valid held -> 7x0x55, 0xD5, 64 bytes, 4 FCS bytes; 76 tx_en cycles; residue of reflected CRC over payload+FCS = 0xDEBB20E3; frame_count=1.
REQ-031 payload "123456789" (9 bytes) -> 51 pad bytes 0x00, 60 bytes pre-FCS, FCS matches software CRC-32 of padded frame; 72 tx_en cycles.
REQ-032 two back-to-back 60-byte frames, in_valid always 1 -> exactly 12 tx_en=0 cycles between last FCS byte and next 0x55; frame_count=2.
REQ-033 in_valid dropped after 20 payload bytes -> underrun pulse 1 cycle, tx_en low next cycle, no FCS, 12 idle cycles, frame_count unchanged.
REQ-034 sys_rst pulsed during byte 30 of DATA -> tx_en=0 within same cycle, frame_count=0; following 60-byte frame transmits correctly.
REQ-035 frame_count preloaded by 65535 completed frames (or forced) -> next frame wraps to 0x0000.
